// File: rtl/draw_rect_anim_pkg.sv
// Shared types and screen geometry for the rectangle drawing stage.
// Pure definitions, no logic; imported by the interface, top and axis sub-module.
// The helper below does the 12-bit span test so x+size can never overflow.
package draw_rect_anim_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    WAIT_VB = 2'd0,
    UPD_X   = 2'd1,
    UPD_Y   = 2'd2
  } state_t;

  // lo <= c < lo+size, evaluated at 12 bits (max 1023+1024 fits)
  function automatic logic in_span(logic [11:0] c, logic [11:0] lo, logic [11:0] size);
    return (c >= lo) && (c < (lo + size));
  endfunction

endpackage

// File: rtl/draw_rect_anim_if.sv
// VGA timing bus (counters and strobes) passed between draw stages.
// No latency of its own; carries one pixel position per clock.
// No backpressure: the timing bus is free-running.
interface draw_rect_anim_if;
  import draw_rect_anim_pkg::*;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/draw_rect_anim_axis.sv
// One axis of the bouncing rectangle: position plus direction, clamped to the screen.
// Position changes on the clock after upd is sampled high.
// No backpressure; upd is a single-cycle strobe.
module rect_bounce_axis #(
  parameter int LIMIT = 1024,
  parameter int SIZE  = 64,
  parameter int STEP  = 4,
  parameter int POS0  = 100
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        upd,
  output logic [10:0] pos
);

  logic [10:0] pos_q, pos_d;
  logic        neg_q, neg_d;   // 1 = moving towards 0
  logic [11:0] far_edge;

  assign far_edge = {1'b0, pos_q} + 12'(STEP + SIZE);
  assign pos      = pos_q;

  // Bounce rule: clamp to the wall and reverse instead of overshooting
  always_comb begin
    pos_d = pos_q;
    neg_d = neg_q;
    if (upd) begin
      if (!neg_q) begin
        if (far_edge >= 12'(LIMIT)) begin
          pos_d = 11'(LIMIT - SIZE);
          neg_d = 1'b1;
        end else begin
          pos_d = pos_q + 11'(STEP);
        end
      end else begin
        if (pos_q <= 11'(STEP)) begin
          pos_d = '0;
          neg_d = 1'b0;
        end else begin
          pos_d = pos_q - 11'(STEP);
        end
      end
    end
  end

  // Position/direction register
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      pos_q <= 11'(POS0);
      neg_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

endmodule

// File: rtl/draw_rect_anim.sv
// Paints background plus one bouncing rectangle; position moves once per frame in vblank.
// Latency 1 clk from timing inputs to timing/rgb outputs, all mutually aligned.
// No backpressure: free-running pixel stream.
module draw_rect_anim
  import draw_rect_anim_pkg::*;
#(
  parameter int   RECT_W   = 64,
  parameter int   RECT_H   = 48,
  parameter int   STEP     = 4,
  parameter int   X0       = 100,
  parameter int   Y0       = 100,
  parameter rgb_t RECT_RGB = 12'hF00,
  parameter rgb_t BG_RGB   = 12'h888
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic             enable,
  draw_rect_anim_if.slave  in_if,
  draw_rect_anim_if.master out_if,
  output rgb_t             rgb_out,
  output logic [15:0]      frame_cnt
);

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  rgb_t        rgb_q, rgb_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        vblnk_dly_q;
  logic        vb_rise;
  state_t      state_q, state_d;
  logic        upd_x, upd_y;
  logic [10:0] x_pos, y_pos;

  rect_bounce_axis #(
    .LIMIT(HOR_PIXELS), .SIZE(RECT_W), .STEP(STEP), .POS0(X0)
  ) u_x (
    .clk65MHz(clk65MHz), .rst(rst), .upd(upd_x), .pos(x_pos)
  );

  rect_bounce_axis #(
    .LIMIT(VER_PIXELS), .SIZE(RECT_H), .STEP(STEP), .POS0(Y0)
  ) u_y (
    .clk65MHz(clk65MHz), .rst(rst), .upd(upd_y), .pos(y_pos)
  );

  assign vb_rise     = in_if.vblnk & ~vblnk_dly_q;
  assign frame_cnt_d = frame_cnt_q + 16'(vb_rise);

  // Colour select for the pixel currently on the input bus
  always_comb begin
    rgb_d = BG_RGB;
    if (in_if.hblnk || in_if.vblnk) begin
      rgb_d = 12'h000;
    end else if (in_span({1'b0, in_if.hcount}, {1'b0, x_pos}, 12'(RECT_W)) &&
                 in_span({1'b0, in_if.vcount}, {1'b0, y_pos}, 12'(RECT_H))) begin
      rgb_d = RECT_RGB;
    end
  end

  // Frame update sequencer; enable only matters at the vblank rising edge
  always_comb begin
    state_d = state_q;
    upd_x   = 1'b0;
    upd_y   = 1'b0;
    case (state_q)
      WAIT_VB: if (vb_rise && enable) state_d = UPD_X;
      UPD_X: begin
        upd_x   = 1'b1;
        state_d = UPD_Y;
      end
      UPD_Y: begin
        upd_y   = 1'b1;
        state_d = WAIT_VB;
      end
      default: state_d = WAIT_VB;
    endcase
  end

  // Output pipeline stage, edge detector, frame counter and FSM state
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
      frame_cnt_q <= '0;
      vblnk_dly_q <= 1'b0;
      state_q     <= WAIT_VB;
    end else begin
      hcount_q    <= in_if.hcount;
      vcount_q    <= in_if.vcount;
      hsync_q     <= in_if.hsync;
      vsync_q     <= in_if.vsync;
      hblnk_q     <= in_if.hblnk;
      vblnk_q     <= in_if.vblnk;
      rgb_q       <= rgb_d;
      frame_cnt_q <= frame_cnt_d;
      vblnk_dly_q <= in_if.vblnk;
      state_q     <= state_d;
    end
  end

  assign out_if.hcount = hcount_q;
  assign out_if.vcount = vcount_q;
  assign out_if.hsync  = hsync_q;
  assign out_if.vsync  = vsync_q;
  assign out_if.hblnk  = hblnk_q;
  assign out_if.vblnk  = vblnk_q;
  assign rgb_out       = rgb_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_draw_rect_anim.sv
// Directed bench: three instances (nominal, right/bottom bounce, left/top clamp) share one
// timing bus; a reference model pushes expected outputs per cycle, popped 1 clk later.
module tb_draw_rect_anim;
  import draw_rect_anim_pkg::*;

  localparam rgb_t RECT_C = 12'hF00;
  localparam rgb_t BG_C   = 12'h888;

  logic clk65MHz = 1'b0;
  always #8 clk65MHz = ~clk65MHz;

  logic rst = 1'b1;
  logic enable = 1'b0;

  draw_rect_anim_if tin();
  draw_rect_anim_if to0();
  draw_rect_anim_if to1();
  draw_rect_anim_if to2();

  rgb_t        rgb0, rgb1, rgb2;
  logic [15:0] fc0, fc1, fc2;

  draw_rect_anim u0 (
    .clk65MHz(clk65MHz), .rst(rst), .enable(enable),
    .in_if(tin), .out_if(to0), .rgb_out(rgb0), .frame_cnt(fc0)
  );
  draw_rect_anim #(.X0(958), .Y0(718)) u1 (
    .clk65MHz(clk65MHz), .rst(rst), .enable(enable),
    .in_if(tin), .out_if(to1), .rgb_out(rgb1), .frame_cnt(fc1)
  );
  draw_rect_anim #(.RECT_W(1018), .RECT_H(762), .X0(2), .Y0(2)) u2 (
    .clk65MHz(clk65MHz), .rst(rst), .enable(enable),
    .in_if(tin), .out_if(to2), .rgb_out(rgb2), .frame_cnt(fc2)
  );

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    rgb_t        r0, r1, r2;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int   mw[3]  = '{64, 64, 1018};
  int   mh[3]  = '{48, 48, 762};
  int   mx0[3] = '{100, 958, 2};
  int   my0[3] = '{100, 718, 2};
  int   mx[3], my[3];
  bit   mnx[3], mny[3];
  logic [15:0] mfc;
  logic mvb_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = mx0[k]; my[k] = my0[k]; mnx[k] = 1'b0; mny[k] = 1'b0;
    end
    mfc = '0;
    mvb_prev = 1'b0;
  endtask

  task automatic bounce(inout int p, inout bit neg, input int size, input int limit);
    if (!neg) begin
      if (p + 4 + size >= limit) begin p = limit - size; neg = 1'b1; end
      else p = p + 4;
    end else begin
      if (p <= 4) begin p = 0; neg = 1'b0; end
      else p = p - 4;
    end
  endtask

  function automatic rgb_t model_rgb(int k, int h, int v, logic hb, logic vb);
    if (hb || vb) return 12'h000;
    if (h >= mx[k] && h < mx[k] + mw[k] && v >= my[k] && v < my[k] + mh[k]) return RECT_C;
    return BG_C;
  endfunction

  // one clock: drive inputs, push expectation, then compare the DUT output
  task automatic cycle(input logic r, input int h, input int v, input logic hb, input logic vb);
    exp_t e, g;
    @(negedge clk65MHz);
    rst        = r;
    tin.hcount = 11'(h);
    tin.vcount = 11'(v);
    tin.hsync  = 1'($urandom_range(0, 1));
    tin.vsync  = 1'($urandom_range(0, 1));
    tin.hblnk  = hb;
    tin.vblnk  = vb;
    if (r) begin
      model_reset();
      e = '{h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0,
            r0: '0, r1: '0, r2: '0, fc: '0};
    end else begin
      logic rise;
      rise = vb & ~mvb_prev;
      if (rise) mfc = mfc + 16'd1;
      e = '{h: tin.hcount, v: tin.vcount, hs: tin.hsync, vs: tin.vsync, hb: hb, vb: vb,
            r0: model_rgb(0, h, v, hb, vb), r1: model_rgb(1, h, v, hb, vb),
            r2: model_rgb(2, h, v, hb, vb), fc: mfc};
      if (rise && enable) begin
        for (int k = 0; k < 3; k++) begin
          bounce(mx[k], mnx[k], mw[k], 1024);
          bounce(my[k], mny[k], mh[k], 768);
        end
      end
      mvb_prev = vb;
    end
    sb.push_back(e);
    @(posedge clk65MHz);
    #1;
    g = sb.pop_front();
    check("hcount", 32'(to0.hcount), 32'(g.h));
    check("vcount", 32'(to0.vcount), 32'(g.v));
    check("hsync",  32'(to0.hsync),  32'(g.hs));
    check("vsync",  32'(to0.vsync),  32'(g.vs));
    check("hblnk",  32'(to0.hblnk),  32'(g.hb));
    check("vblnk",  32'(to0.vblnk),  32'(g.vb));
    check("u1_hcount", 32'(to1.hcount), 32'(g.h));
    check("u2_vcount", 32'(to2.vcount), 32'(g.v));
    check("rgb0", 32'(rgb0), 32'(g.r0));
    check("rgb1", 32'(rgb1), 32'(g.r1));
    check("rgb2", 32'(rgb2), 32'(g.r2));
    check("frame_cnt0", 32'(fc0), 32'(g.fc));
    check("frame_cnt1", 32'(fc1), 32'(g.fc));
    check("frame_cnt2", 32'(fc2), 32'(g.fc));
  endtask

  function automatic int clampi(int a, int hi);
    if (a < 0) return 0;
    if (a > hi) return hi;
    return a;
  endfunction

  // visit the corners/edges of every rectangle, a blanked pixel, then vblank
  task automatic frame();
    for (int k = 0; k < 3; k++) begin
      int xs[4], ys[4];
      xs = '{mx[k] - 1, mx[k], mx[k] + mw[k] - 1, mx[k] + mw[k]};
      ys = '{my[k] - 1, my[k], my[k] + mh[k] - 1, my[k] + mh[k]};
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          cycle(1'b0, clampi(xs[i], 1023), clampi(ys[j], 767), 1'b0, 1'b0);
    end
    cycle(1'b0, 1100, 120, 1'b1, 1'b0);
    cycle(1'b0, 120, 790, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 300 + i, 780, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    tin.hcount = '0; tin.vcount = '0; tin.hsync = 1'b0; tin.vsync = 1'b0;
    tin.hblnk = 1'b0; tin.vblnk = 1'b0;
    model_reset();

    // reset state, then a frozen frame
    cycle(1'b1, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 5, 5, 1'b0, 1'b1);
    frame();
    frame();

    // animated frames: nominal advance, right/bottom bounce, left/top clamp
    enable = 1'b1;
    for (int f = 0; f < 5; f++) frame();

    // enable dropped mid-frame: position frozen, frame counter keeps running
    cycle(1'b0, 110, 110, 1'b0, 1'b0);
    enable = 1'b0;
    frame();
    frame();
    cycle(1'b0, 200, 200, 1'b0, 1'b0);
    enable = 1'b1;
    frame();
    frame();

    // reset pulse mid-frame, then drawing resumes from the reset position
    cycle(1'b0, 499, 300, 1'b0, 1'b0);
    cycle(1'b1, 500, 300, 1'b0, 1'b0);
    cycle(1'b0, 100, 100, 1'b0, 1'b0);
    cycle(1'b0, 99, 100, 1'b0, 1'b0);
    frame();
    frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
